// File: rtl/fp_result_packer.sv
// fp_result_packer: pairs each op issued to fp_unit with its in-order result and
// emits 288-bit test-vector records over a valid/ready drain port.
module fp_result_packer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     iss_valid,
    output logic                     iss_ready,
    input  logic [63:0]              iss_data1,
    input  logic [63:0]              iss_data2,
    input  logic [63:0]              iss_data3,
    input  logic [1:0]               iss_fmt,
    input  logic [2:0]               iss_rm,
    input  logic [1:0]               iss_op,
    input  logic [9:0]               iss_opcode,
    input  logic                     res_ready,
    input  logic [63:0]              res_result,
    input  logic [4:0]               res_flags,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [287:0]             rec_data,
    output logic [$clog2(DEPTH):0]   pend_cnt,
    output logic [$clog2(DEPTH):0]   out_cnt,
    output logic                     ovf_err,
    output logic                     unexp_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 209;
    localparam int unsigned RW = 288;

    // Pending entry layout: [208:17] data1..3, [16:15] fmt, [14:12] rm, [11:10] op, [9:0] opcode
    logic [EW-1:0] pend_mem [DEPTH];
    logic [RW-1:0] out_mem  [DEPTH];

    logic [PW-1:0] pend_wr_ptr, pend_rd_ptr;
    logic [PW-1:0] out_wr_ptr, out_rd_ptr;

    logic          iss_push;
    logic          res_pop;
    logic          rec_pop;
    logic [CW:0]   credit_sum_c;
    logic [EW-1:0] iss_entry_c;
    logic [EW-1:0] pend_head_c;
    logic [RW-1:0] rec_new_c;

    // Handshake qualifiers and record assembly from the oldest pending op
    always_comb begin
        credit_sum_c = {1'b0, pend_cnt} + {1'b0, out_cnt};
        iss_ready    = credit_sum_c < (CW+1)'(DEPTH);
        iss_push     = iss_valid && iss_ready;
        res_pop      = res_ready && (pend_cnt != '0);
        rec_valid    = out_cnt != '0;
        rec_pop      = rec_valid && rec_ready;
        iss_entry_c  = {iss_data1, iss_data2, iss_data3, iss_fmt, iss_rm, iss_op, iss_opcode};
        pend_head_c  = pend_mem[pend_rd_ptr];
        rec_new_c    = {pend_head_c[208:17], res_result,
                        3'b000, res_flags,
                        2'b00, pend_head_c[16:15],
                        1'b0, pend_head_c[14:12],
                        2'b00, pend_head_c[11:10],
                        2'b00, pend_head_c[9:0]};
        rec_data     = rec_valid ? out_mem[out_rd_ptr] : '0;
    end

    // Queue storage; contents beyond the counts are don't-care, so no reset
    always_ff @(posedge clock) begin
        if (iss_push) pend_mem[pend_wr_ptr] <= iss_entry_c;
        if (res_pop)  out_mem[out_wr_ptr]   <= rec_new_c;
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_wr_ptr <= '0;
            pend_rd_ptr <= '0;
            out_wr_ptr  <= '0;
            out_rd_ptr  <= '0;
        end else begin
            if (iss_push) pend_wr_ptr <= pend_wr_ptr + PW'(1);
            if (res_pop)  pend_rd_ptr <= pend_rd_ptr + PW'(1);
            if (res_pop)  out_wr_ptr  <= out_wr_ptr + PW'(1);
            if (rec_pop)  out_rd_ptr  <= out_rd_ptr + PW'(1);
        end
    end

    // Occupancy counts, each with its own net +1/0/-1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_cnt <= '0;
            out_cnt  <= '0;
        end else begin
            case ({iss_push, res_pop})
                2'b10:   pend_cnt <= pend_cnt + CW'(1);
                2'b01:   pend_cnt <= pend_cnt - CW'(1);
                default: pend_cnt <= pend_cnt;
            endcase
            case ({res_pop, rec_pop})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                2'b01:   out_cnt <= out_cnt - CW'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    // Sticky protocol error flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_err   <= 1'b0;
            unexp_err <= 1'b0;
        end else begin
            if (iss_valid && !iss_ready)      ovf_err   <= 1'b1;
            if (res_ready && pend_cnt == '0)  unexp_err <= 1'b1;
        end
    end

endmodule
